// File: rtl/wave_arb_pkg.sv
// rtl/wave_arb_pkg.sv - shared types and helpers for the wave ROM arbiter
package wave_arb_pkg;

    // Upper bound on player channels sharing one memory port
    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RETURN = 2'd2
    } arb_state_e;

    // Pick the even (low) or odd (high) byte out of a memory word
    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/wave_arb_rr.sv
// rtl/wave_arb_rr.sv - combinational round-robin picker for the wave ROM arbiter
module wave_arb_rr #(
    parameter int NUM_CH = 4,
    parameter int IW     = 2
) (
    input  logic [NUM_CH-1:0] pend,
    input  logic [IW-1:0]     rr,
    output logic [IW-1:0]     grant,
    output logic              any_vld
);

    logic [IW:0] sum;
    logic [IW:0] wrapped;
    logic        found;

    assign any_vld = |pend;

    // Scan channels starting at rr with wrap; the first pending one wins
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        sum     = '0;
        wrapped = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum     = {1'b0, rr} + (IW+1)'(i);
            wrapped = (sum >= (IW+1)'(NUM_CH)) ? (sum - (IW+1)'(NUM_CH)) : sum;
            if (!found && pend[wrapped[IW-1:0]]) begin
                found = 1'b1;
                grant = wrapped[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/wave_rom_arbiter.sv
// rtl/wave_rom_arbiter.sv - round-robin byte ports onto one 16-bit sample memory; option macro WAVE_ARB_WORD_HOLD_EN
module wave_rom_arbiter
    import wave_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int AW     = 28
) (
    input  logic                 I_CLK,
    input  logic                 I_RST_N,
    input  logic [NUM_CH*AW-1:0] I_ADDR,
    input  logic [NUM_CH-1:0]    I_READ,
    output logic [NUM_CH*8-1:0]  O_DATA,
    output logic [NUM_CH-1:0]    O_READY,
    output logic [AW-2:0]        O_MEM_ADDR,
    output logic                 O_MEM_REQ,
    input  logic [15:0]          I_MEM_DATA,
    input  logic                 I_MEM_ACK
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_e          state_q, state_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [AW-1:0]       addr_q [NUM_CH];
    logic [AW-1:0]       addr_d [NUM_CH];
    logic [NUM_CH*8-1:0] data_q, data_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [IW-1:0]       pick;
    logic                any_vld;
    logic                mem_req_q, mem_req_d;
    logic [AW-2:0]       mem_addr_q, mem_addr_d;
    logic [7:0]          byte_q, byte_d;
    logic [NUM_CH-1:0]   rdy;

`ifdef WAVE_ARB_WORD_HOLD_EN
    logic [15:0]         hold_word_q [NUM_CH];
    logic [15:0]         hold_word_d [NUM_CH];
    logic [AW-2:0]       hold_tag_q  [NUM_CH];
    logic [AW-2:0]       hold_tag_d  [NUM_CH];
    logic [NUM_CH-1:0]   hold_vld_q, hold_vld_d;
    logic [NUM_CH-1:0]   local_q, local_d;

    // A channel is busy while waiting on memory or on its one-cycle local hit
    assign rdy = ~(pend_q | local_q);
`else
    assign rdy = ~pend_q;
`endif

    assign O_READY    = rdy;
    assign O_DATA     = data_q;
    assign O_MEM_REQ  = mem_req_q;
    assign O_MEM_ADDR = mem_addr_q;

    wave_arb_rr #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_rr (
        .pend    (pend_q),
        .rr      (rr_q),
        .grant   (pick),
        .any_vld (any_vld)
    );

    // Capture channel strobes, then run the one-at-a-time fetch sequence
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        addr_d     = addr_q;
        data_d     = data_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        byte_d     = byte_q;
`ifdef WAVE_ARB_WORD_HOLD_EN
        hold_word_d = hold_word_q;
        hold_tag_d  = hold_tag_q;
        hold_vld_d  = hold_vld_q;
        local_d     = local_q;

        // Local hits complete one cycle after capture, straight from the held word
        for (int n = 0; n < NUM_CH; n++) begin
            if (local_q[n]) begin
                data_d[n*8 +: 8] = byte_sel(hold_word_q[n], addr_q[n][0]);
                local_d[n]       = 1'b0;
            end
        end
`endif

        for (int n = 0; n < NUM_CH; n++) begin
            if (I_READ[n] && rdy[n]) begin
                addr_d[n] = I_ADDR[n*AW +: AW];
`ifdef WAVE_ARB_WORD_HOLD_EN
                if (hold_vld_q[n] && (I_ADDR[n*AW+1 +: AW-1] == hold_tag_q[n])) begin
                    local_d[n] = 1'b1;
                end else begin
                    pend_d[n] = 1'b1;
                end
`else
                pend_d[n] = 1'b1;
`endif
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (any_vld) begin
                    grant_d    = pick;
                    mem_addr_d = addr_q[pick][AW-1:1];
                    mem_req_d  = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (I_MEM_ACK) begin
                    mem_req_d = 1'b0;
                    byte_d    = byte_sel(I_MEM_DATA, addr_q[grant_q][0]);
                    state_d   = ST_RETURN;
`ifdef WAVE_ARB_WORD_HOLD_EN
                    hold_word_d[grant_q] = I_MEM_DATA;
                    hold_tag_d[grant_q]  = mem_addr_q;
                    hold_vld_d[grant_q]  = 1'b1;
`endif
                end
            end
            ST_RETURN: begin
                // Data and ready move together so O_DATA only changes as ready rises
                pend_d[grant_q]        = 1'b0;
                data_d[grant_q*8 +: 8] = byte_q;
                rr_d    = (grant_q == IW'(NUM_CH-1)) ? '0 : grant_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            data_q     <= '0;
            grant_q    <= '0;
            rr_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            byte_q     <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                addr_q[n] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            byte_q     <= byte_d;
            addr_q     <= addr_d;
        end
    end

`ifdef WAVE_ARB_WORD_HOLD_EN
    // Per-channel word hold registers; reset invalidates every entry
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            hold_vld_q <= '0;
            local_q    <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                hold_word_q[n] <= '0;
                hold_tag_q[n]  <= '0;
            end
        end else begin
            hold_vld_q  <= hold_vld_d;
            local_q     <= local_d;
            hold_word_q <= hold_word_d;
            hold_tag_q  <= hold_tag_d;
        end
    end
`endif

endmodule
